pattern_decoder: RTL and testbench
==================================

// Module: pattern_decoder
// PURPOSE
//  Parametrised serial pattern detector: successor to the fixed 4-bit decoder.
//  - Pattern shifted in serially on prgm; signal stream shifted in serially on sig.
//  - Qualified loading, an explicit load/armed FSM, fill tracking and overlapping-match detection.
//  - Sits between the serial front end and the event logic; out is one registered pulse per match.
// PARAMETERS
//  WIDTH    4   pattern/window length in bits (2..32)
//  CNT_W    8   match counter width (used only with PD_MATCH_CNT_EN)
// PORTS
//  clk          in   1        rising-edge clock, sole clock domain
//  clr          in   1        synchronous active-high reset
//  prgm         in   1        pattern bit, sampled when prgm_valid=1
//  prgm_valid   in   1        qualifies prgm
//  sig          in   1        signal bit, sampled when sig_valid=1
//  sig_valid    in   1        qualifies sig
//  out          out  1        one-cycle match pulse (registered)
//  armed        out  1        1 = full pattern loaded, detection active
//  match_cnt    out  CNT_W    saturating match count (0 when macro off)
// BEHAVIOUR
//  Reset: clr=1 at edge -> state=IDLE, pattern/window regs=0, counts=0,
//   out=0, armed=0, match_cnt=0. clr overrides every other input.
//  Shift: both regs shift left; new bit enters bit 0. First pattern bit loaded = MSB.
//  FSM (registered state, armed = (state==ARMED)):
//   IDLE    : prgm_valid -> LOAD, pattern bit captured, load_cnt=1.
//   LOAD    : each prgm_valid shifts a bit in. The WIDTH-th bit -> ARMED next cycle.
//             sig/sig_valid ignored; window and fill count held at 0.
//   ARMED   : sig_valid shifts sig into window; fill_cnt increments, saturating at WIDTH.
//             prgm_valid -> LOAD with load_cnt=1 and this bit captured.
//             On that transition: window, fill_cnt and out cleared.
//  Match: evaluated on the bit just accepted (next-window value).
//   out=1 on the edge that accepts sig when state==ARMED, fill reaches WIDTH with
//   this bit, and the next window equals the pattern. Otherwise out=0.
//   - Latency: visible in the cycle after the completing sig_valid cycle; pulse lasts 1 cycle.
//   - Overlapping matches detected; the window is not flushed after a match.
//   - Window holds while sig_valid=0; out=0 on idle cycles.
//  Simultaneous prgm_valid & sig_valid in ARMED: prgm wins; sig bit dropped, no match.
//  Fill guard: no match until WIDTH sig bits accepted since arming/reprogram,
//   so an all-zero pattern cannot match the reset-zero window.
//  clr mid-LOAD or mid-stream: everything discarded, back to IDLE; pattern must be reloaded.
// CONFIGURATION
//  PD_MATCH_CNT_EN defined: match_cnt increments on every out pulse.
//   - Saturates at 2^CNT_W-1.
//   - Cleared by clr and on entry to LOAD.
//  PD_MATCH_CNT_EN undefined: no counter logic; match_cnt tied to 0.
// TESTING (WIDTH=4, CNT_W=2, PD_MATCH_CNT_EN defined)
//  1 clr, load 1,0,1,1 -> armed=1 the cycle after 4th bit; sig 1,0,1,1 -> one out pulse
//    after 4th sig bit; match_cnt=1.
//  2 pattern 1010, sig 1,0,1,0,1,0 -> out pulses after bits 4 and 6 (overlap); match_cnt=2.
//  3 pattern 0000, sig 0,0,0 -> no out; 4th 0 -> out=1; sig_valid gaps between bits
//    -> same result, out=0 in gap cycles.
//  4 armed with 1011, sig 1,0,1, then prgm_valid & sig_valid same cycle
//    -> state LOAD, armed=0, out=0, window/fill/match_cnt cleared.
//  5 clr asserted after 2 of 4 pattern bits -> IDLE, armed=0; sig stream 1011 -> no out.
//  6 pattern 1111, sig of 1s -> out pulses at bits 4,5,6,7...; match_cnt saturates at 3.

Source files
------------

// File: rtl/pattern_decoder.sv
// Serial pattern detector: load a WIDTH-bit pattern on prgm, then flag every (overlapping) match on sig.
// Latency: out pulses one cycle after the sig_valid cycle that completes a match; armed follows the last pattern bit by one cycle.
// No backpressure: every qualified bit is consumed on its cycle; prgm_valid wins over sig_valid. Optional: PD_MATCH_CNT_EN.
module pattern_decoder #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             prgm,
  input  logic             prgm_valid,
  input  logic             sig,
  input  logic             sig_valid,
  output logic             out,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(WIDTH);
  localparam logic [FW-1:0] LOAD_LAST = FW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [WIDTH-1:0] window_q, window_d;
  logic [FW-1:0]    load_cnt_q, load_cnt_d;
  logic [FW-1:0]    fill_cnt_q, fill_cnt_d;
  logic             out_q, out_d;
  logic             hit;

  logic [WIDTH-1:0] pattern_shift;
  logic [WIDTH-1:0] window_shift;
  logic [FW-1:0]    fill_inc;

  // Both registers shift left; the first pattern bit ends up as the MSB.
  assign pattern_shift = {pattern_q[WIDTH-2:0], prgm};
  assign window_shift  = {window_q[WIDTH-2:0], sig};
  assign fill_inc      = (fill_cnt_q == FILL_MAX) ? FILL_MAX : fill_cnt_q + FW'(1);

  // Next-state logic: pattern loading, arming, window fill and match detection.
  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    window_d   = window_q;
    load_cnt_d = load_cnt_q;
    fill_cnt_d = fill_cnt_q;
    hit        = 1'b0;
    case (state_q)
      S_IDLE: begin
        window_d   = '0;
        fill_cnt_d = '0;
        if (prgm_valid) begin
          state_d    = S_LOAD;
          pattern_d  = pattern_shift;
          load_cnt_d = FW'(1);
        end
      end
      S_LOAD: begin
        window_d   = '0;
        fill_cnt_d = '0;
        if (prgm_valid) begin
          pattern_d  = pattern_shift;
          load_cnt_d = load_cnt_q + FW'(1);
          if (load_cnt_q == LOAD_LAST) begin
            state_d = S_ARMED;
          end
        end
      end
      S_ARMED: begin
        if (prgm_valid) begin
          // Reprogram: the sig bit of this cycle (if any) is dropped.
          state_d    = S_LOAD;
          pattern_d  = pattern_shift;
          load_cnt_d = FW'(1);
          window_d   = '0;
          fill_cnt_d = '0;
        end else if (sig_valid) begin
          window_d   = window_shift;
          fill_cnt_d = fill_inc;
          // Fill guard keeps a zero pattern from matching the cleared window.
          hit        = (fill_inc == FILL_MAX) && (window_shift == pattern_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    out_d = hit;
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      window_q   <= '0;
      load_cnt_q <= '0;
      fill_cnt_q <= '0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      window_q   <= window_d;
      load_cnt_q <= load_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      out_q      <= out_d;
    end
  end

  assign out   = out_q;
  assign armed = (state_q == S_ARMED);

`ifdef PD_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             restart;

  // Any accepted pattern bit outside LOAD starts a fresh load.
  assign restart = prgm_valid && (state_q != S_LOAD);

  // Saturating match counter, cleared whenever a new load begins.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (restart) begin
      match_cnt_d = '0;
    end else if (hit && (match_cnt_q != '1)) begin
      match_cnt_d = match_cnt_q + CNT_W'(1);
    end
  end

  // Match counter register.
  always_ff @(posedge clk) begin
    if (clr) begin
      match_cnt_q <= '0;
    end else begin
      match_cnt_q <= match_cnt_d;
    end
  end

  assign match_cnt = match_cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_decoder.sv
// Testbench for pattern_decoder: directed scenarios with literal expectations plus randomized traffic.
// Every cycle after the first clear, DUT outputs are compared against a behavioural model.
// Inputs change at the falling edge; outputs are sampled at the falling edge.
module tb_pattern_decoder;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PD_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             prgm = 1'b0;
  logic             prgm_valid = 1'b0;
  logic             sig = 1'b0;
  logic             sig_valid = 1'b0;
  logic             out;
  logic             armed;
  logic [CNT_W-1:0] match_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pattern_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .prgm       (prgm),
    .prgm_valid (prgm_valid),
    .sig        (sig),
    .sig_valid  (sig_valid),
    .out        (out),
    .armed      (armed),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cexp(input int v);
    return CNT_ON ? v : 0;
  endfunction

  // Behavioural model: counts of bits loaded/accepted and integer pattern/window values.
  bit m_valid = 1'b0;
  int n_loaded, n_sig, m_pat, m_win, m_cnt;
  bit e_out;

  always @(posedge clk) begin
    if (clr) begin
      m_valid = 1'b1;
      n_loaded = 0; n_sig = 0; m_pat = 0; m_win = 0; m_cnt = 0; e_out = 1'b0;
    end else if (m_valid) begin
      e_out = 1'b0;
      if (prgm_valid) begin
        m_pat = ((m_pat << 1) | int'(prgm)) & MASK;
        if (n_loaded == 0 || n_loaded == WIDTH) begin
          n_loaded = 1; n_sig = 0; m_win = 0; m_cnt = 0;
        end else begin
          n_loaded++;
        end
      end else if (sig_valid && n_loaded == WIDTH) begin
        m_win = ((m_win << 1) | int'(sig)) & MASK;
        n_sig++;
        if (n_sig >= WIDTH && m_win == m_pat) begin
          e_out = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_out", {31'd0, out}, {31'd0, e_out});
      chk("m_armed", {31'd0, armed}, (n_loaded == WIDTH) ? 32'd1 : 32'd0);
      chk("m_cnt", {30'd0, match_cnt}, cexp(m_cnt));
    end
  end

  task automatic step(input bit c, input bit pv, input bit p, input bit sv, input bit s);
    clr = c; prgm_valid = pv; prgm = p; sig_valid = sv; sig = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [3:0] pat);
    for (int i = WIDTH - 1; i >= 0; i--) step(0, 1, pat[i], 0, 0);
  endtask

  initial begin
    logic [3:0] sv_bits;
    @(negedge clk);

    // Test 1: reset state, load 1011, single match.
    step(1, 0, 0, 0, 0);
    chk("rst_out", {31'd0, out}, 0);
    chk("rst_armed", {31'd0, armed}, 0);
    chk("rst_cnt", {30'd0, match_cnt}, 0);
    step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0);
    chk("t1_arm3", {31'd0, armed}, 0);
    step(0, 1, 1, 0, 0);
    chk("t1_arm4", {31'd0, armed}, 1);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1);
    chk("t1_out3", {31'd0, out}, 0);
    step(0, 0, 0, 1, 1);
    chk("t1_out4", {31'd0, out}, 1);
    chk("t1_cnt", {30'd0, match_cnt}, cexp(1));
    step(0, 0, 0, 0, 0);
    chk("t1_idle", {31'd0, out}, 0);

    // Test 2: overlapping matches of 1010.
    step(1, 0, 0, 0, 0);
    load(4'b1010);
    sv_bits = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 1, sv_bits[3 - (i % 4)]);
      chk("t2_out", {31'd0, out}, (i == 3 || i == 5) ? 32'd1 : 32'd0);
    end
    chk("t2_cnt", {30'd0, match_cnt}, cexp(2));

    // Test 3: all-zero pattern needs a full window, with and without gaps.
    step(1, 0, 0, 0, 0);
    load(4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      chk("t3_out", {31'd0, out}, (i == 3) ? 32'd1 : 32'd0);
    end
    step(1, 0, 0, 0, 0);
    load(4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      chk("t3g_out", {31'd0, out}, (i == 3) ? 32'd1 : 32'd0);
      step(0, 0, 0, 0, 0);
      chk("t3g_gap", {31'd0, out}, 0);
    end

    // Test 4: reprogram collides with a sig bit; window and count restart.
    step(1, 0, 0, 0, 0);
    load(4'b1011);
    step(0, 0, 0, 1, 1); step(0, 0, 0, 1, 0); step(0, 0, 0, 1, 1);
    step(0, 1, 1, 1, 1);
    chk("t4_armed", {31'd0, armed}, 0);
    chk("t4_out", {31'd0, out}, 0);
    chk("t4_cnt", {30'd0, match_cnt}, 0);
    step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 0);
    chk("t4_rearm", {31'd0, armed}, 1);
    sv_bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, sv_bits[3 - i]);
      chk("t4_out2", {31'd0, out}, (i == 3) ? 32'd1 : 32'd0);
    end

    // Test 5: clear in mid-load discards the partial pattern.
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0); step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, sv_bits[3 - i]);
      chk("t5_out", {31'd0, out}, 0);
      chk("t5_armed", {31'd0, armed}, 0);
    end

    // Test 6: run of ones against 1111, counter saturates.
    step(1, 0, 0, 0, 0);
    load(4'b1111);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 1, 1);
      chk("t6_out", {31'd0, out}, (i >= 3) ? 32'd1 : 32'd0);
      chk("t6_cnt", {30'd0, match_cnt}, cexp((i < 3) ? 0 : ((i - 2 > CMAX) ? CMAX : i - 2)));
    end

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
